// File: rtl/gpio_cfg_loader.sv
// Loads the pad-control chain: snapshots the per-pad config file, shifts it out MSB-first, then pulses serial_load.
// busy for 2*CLK_DIV*(TOTAL+1) cycles after xfer_start; writes and starts are ignored while busy (writes flag cfg_wr_err).
module gpio_cfg_loader #(
  parameter int NUM_PADS = 6,
  parameter int PAD_CTRL_BITS = 12,
  parameter logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULT = 12'hC00,
  parameter int CLK_DIV = 2,
  localparam int AW = $clog2(NUM_PADS)
) (
  input  logic                     mclk,
  input  logic                     resetn,
  input  logic                     cfg_wr,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0] cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0] cfg_rdata,
  output logic                     cfg_wr_err,
  input  logic                     xfer_start,
  output logic                     busy,
  output logic                     done,
  output logic                     serial_clock,
  output logic                     serial_data,
  output logic                     serial_load
);

  localparam int TOTAL = NUM_PADS * PAD_CTRL_BITS;
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(TOTAL + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SHIFT_LO = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] LOAD_LO  = 3'd3;
  localparam logic [2:0] LOAD_HI  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [PAD_CTRL_BITS-1:0] words [NUM_PADS];
  logic [TOTAL-1:0]         file_flat;
  logic [TOTAL-1:0]         snap;
  logic [2:0]               state;
  logic [PW-1:0]            phase;
  logic [BW-1:0]            bit_cnt;
  logic                     addr_ok;
  logic                     wr_ok;
  logic                     phase_end;

  // word[NUM_PADS-1] sits at the top of the flat image so the MSB leaves first
  always_comb begin
    file_flat = '0;
    cfg_rdata = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      file_flat[i*PAD_CTRL_BITS +: PAD_CTRL_BITS] = words[i];
      if (cfg_addr == AW'(i)) cfg_rdata = words[i];
    end
  end

  assign addr_ok   = (32'(cfg_addr) < NUM_PADS);
  assign busy      = (state != IDLE) && (state != DONE);
  assign wr_ok     = cfg_wr && !busy && addr_ok;
  assign phase_end = (phase == PW'(CLK_DIV - 1));

  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_PADS; i++) words[i] <= GPIO_DEFAULT;
      cfg_wr_err <= 1'b0;
    end else begin
      cfg_wr_err <= cfg_wr && !wr_ok;
      if (wr_ok) begin
        for (int i = 0; i < NUM_PADS; i++)
          if (cfg_addr == AW'(i)) words[i] <= cfg_wdata;
      end
    end
  end

  // The snapshot reads the file before this edge's write lands, so a same-cycle write ships next time
  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      snap    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer_start) begin
            snap    <= file_flat;
            bit_cnt <= '0;
            phase   <= '0;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            phase <= '0;
            state <= SHIFT_HI;
          end else phase <= phase + 1'b1;
        end
        SHIFT_HI: begin
          if (phase_end) begin
            phase <= '0;
            if (bit_cnt == BW'(TOTAL - 1)) state <= LOAD_LO;
            else begin
              snap    <= {snap[TOTAL-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              state   <= SHIFT_LO;
            end
          end else phase <= phase + 1'b1;
        end
        LOAD_LO: begin
          if (phase_end) begin
            phase <= '0;
            state <= LOAD_HI;
          end else phase <= phase + 1'b1;
        end
        LOAD_HI: begin
          if (phase_end) begin
            phase <= '0;
            state <= DONE;
          end else phase <= phase + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign serial_clock = (state == SHIFT_HI);
  assign serial_data  = ((state == SHIFT_LO) || (state == SHIFT_HI)) && snap[TOTAL-1];
  assign serial_load  = (state == LOAD_HI);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: scoreboarded serial bit stream plus a behavioural pad chain, CLK_DIV=2 and CLK_DIV=1 instances.
module tb_gpio_cfg_loader;
  localparam int NP = 6;
  localparam int W = 12;
  localparam int TOTAL = NP * W;
  localparam logic [11:0] DEF = 12'hC00;

  logic mclk = 1'b0;
  logic resetn = 1'b1;
  always #5 mclk = ~mclk;

  logic cfg_wr = 1'b0, xfer_start = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [11:0] cfg_wdata = 12'd0;
  logic [11:0] cfg_rdata;
  logic cfg_wr_err, busy, done, serial_clock, serial_data, serial_load;

  logic wr1 = 1'b0, start1 = 1'b0;
  logic [2:0] addr1 = 3'd0;
  logic [11:0] wdata1 = 12'd0;
  logic [11:0] rdata1;
  logic err1, busy1, done1, sclk1, sdata1, sload1;

  gpio_cfg_loader #(.NUM_PADS(NP), .PAD_CTRL_BITS(W), .GPIO_DEFAULT(DEF), .CLK_DIV(2)) u_dut (
    .mclk(mclk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_wr_err(cfg_wr_err), .xfer_start(xfer_start), .busy(busy),
    .done(done), .serial_clock(serial_clock), .serial_data(serial_data), .serial_load(serial_load));

  gpio_cfg_loader #(.NUM_PADS(NP), .PAD_CTRL_BITS(W), .GPIO_DEFAULT(DEF), .CLK_DIV(1)) u_dut_div1 (
    .mclk(mclk), .resetn(resetn), .cfg_wr(wr1), .cfg_addr(addr1), .cfg_wdata(wdata1),
    .cfg_rdata(rdata1), .cfg_wr_err(err1), .xfer_start(start1), .busy(busy1),
    .done(done1), .serial_clock(sclk1), .serial_data(sdata1), .serial_load(sload1));

  int errors = 0;
  int checks = 0;
  logic [11:0] model [NP];
  logic [11:0] model1 [NP];
  bit exp_q[$];
  bit exp_q1[$];
  logic [TOTAL-1:0] chain = '0;
  logic [TOTAL-1:0] latched = '0;
  int rises = 0, load_cyc = 0, busy_cyc = 0, done_cnt = 0;
  int rises1 = 0, busy_cyc1 = 0, done_cnt1 = 0;
  logic sclk_prev = 1'b0, sload_prev = 1'b0, sclk1_prev = 1'b0;

  // Monitor for the CLK_DIV=2 instance: scoreboard pop on each serial_clock rise, chain model, counters
  always @(negedge mclk) begin : mon_a
    bit e;
    if (serial_clock && !sclk_prev) begin
      rises++;
      chain = {chain[TOTAL-2:0], serial_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bit_extra: rise %0d got %b, no bit expected", rises, serial_data);
      end else begin
        e = exp_q.pop_front();
        if (serial_data !== e) begin
          errors++;
          $display("FAIL bit_order: rise %0d got %b want %b", rises, serial_data, e);
        end
      end
    end
    if (serial_load) begin
      load_cyc++;
      if (!sload_prev) latched = chain;
      checks++;
      if (serial_clock !== 1'b0) begin
        errors++;
        $display("FAIL load_clk_overlap: serial_clock=%b want 0 while serial_load=1", serial_clock);
      end
    end
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    sclk_prev = serial_clock;
    sload_prev = serial_load;
  end

  always @(negedge mclk) begin : mon_b
    bit e;
    if (sclk1 && !sclk1_prev) begin
      rises1++;
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL div1_bit_extra: rise %0d got %b, no bit expected", rises1, sdata1);
      end else begin
        e = exp_q1.pop_front();
        if (sdata1 !== e) begin
          errors++;
          $display("FAIL div1_bit_order: rise %0d got %b want %b", rises1, sdata1, e);
        end
      end
    end
    if (busy1) busy_cyc1++;
    if (done1) done_cnt1++;
    sclk1_prev = sclk1;
  end

  task automatic reset_models();
    for (int i = 0; i < NP; i++) begin
      model[i] = DEF;
      model1[i] = DEF;
    end
    exp_q.delete();
    exp_q1.delete();
  endtask

  task automatic kick();
    rises = 0; load_cyc = 0; busy_cyc = 0; done_cnt = 0;
    for (int p = NP - 1; p >= 0; p--)
      for (int b = W - 1; b >= 0; b--) exp_q.push_back(model[p][b]);
    xfer_start = 1'b1;
    @(negedge mclk);
    xfer_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 5000) begin
      @(negedge mclk);
      t++;
    end
    ok = (done_cnt != 0);
    @(negedge mclk);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [11:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge mclk);
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge mclk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, cfg_wr_err, serial_clock, serial_data, serial_load} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {busy, done, cfg_wr_err, serial_clock, serial_data, serial_load});
    end
    reset_models();
    repeat (2) @(negedge mclk);
    resetn = 1'b1;
    @(negedge mclk);
    for (int a = 0; a < NP; a++) begin
      cfg_addr = 3'(a);
      #1;
      checks++;
      if (cfg_rdata !== DEF) begin
        errors++;
        $display("FAIL reset_rdata: addr %0d got %h want %h", a, cfg_rdata, DEF);
      end
    end
    @(negedge mclk);
  endtask

  task automatic test_default_xfer();
    bit ok;
    kick();
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL default_timeout: done not seen within bound"); end
    checks++;
    if (busy_cyc !== 292) begin errors++; $display("FAIL default_busy: got %0d cycles want 292", busy_cyc); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL default_done: got %0d pulses want 1", done_cnt); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL default_done_width: done=%b want 0 one cycle later", done); end
    checks++;
    if (rises !== 72) begin errors++; $display("FAIL default_rises: got %0d want 72", rises); end
    checks++;
    if (load_cyc !== 2) begin errors++; $display("FAIL default_load: got %0d cycles want 2", load_cyc); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL default_bits_left: got %0d unsent want 0", exp_q.size()); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (latched[p*W +: W] !== DEF) begin
        errors++;
        $display("FAIL default_pad: pad %0d got %h want %h", p, latched[p*W +: W], DEF);
      end
    end
  endtask

  task automatic test_pattern();
    bit ok;
    cfg_write(3'd5, 12'hABC); model[5] = 12'hABC;
    cfg_write(3'd0, 12'h123); model[0] = 12'h123;
    kick();
    wait_done(ok);
    checks++;
    if (!ok || busy_cyc !== 292) begin
      errors++;
      $display("FAIL pattern_busy: got %0d cycles (done seen %b) want 292", busy_cyc, ok);
    end
    checks++;
    if (latched[5*W +: W] !== 12'hABC) begin errors++; $display("FAIL pattern_pad5: got %h want abc", latched[5*W +: W]); end
    checks++;
    if (latched[0 +: W] !== 12'h123) begin errors++; $display("FAIL pattern_pad0: got %h want 123", latched[0 +: W]); end
    checks++;
    if (latched[3*W +: W] !== DEF) begin errors++; $display("FAIL pattern_pad3: got %h want %h", latched[3*W +: W], DEF); end
  endtask

  task automatic test_busy_write();
    bit ok;
    kick();
    repeat (20) @(negedge mclk);
    cfg_write(3'd2, 12'hFFF);
    checks++;
    if (cfg_wr_err !== 1'b1) begin errors++; $display("FAIL busy_wr_err: got %b want 1", cfg_wr_err); end
    @(negedge mclk);
    checks++;
    if (cfg_wr_err !== 1'b0) begin errors++; $display("FAIL busy_wr_err_width: got %b want 0", cfg_wr_err); end
    xfer_start = 1'b1;
    @(negedge mclk);
    xfer_start = 1'b0;
    wait_done(ok);
    repeat (400) @(negedge mclk);
    checks++;
    if (!ok || done_cnt !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (busy_cyc !== 292 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_restart: busy cycles %0d busy=%b want 292 and 0", busy_cyc, busy);
    end
    cfg_addr = 3'd2;
    #1;
    checks++;
    if (cfg_rdata !== model[2]) begin errors++; $display("FAIL busy_word2: got %h want %h", cfg_rdata, model[2]); end
    @(negedge mclk);
  endtask

  task automatic test_bad_addr();
    cfg_write(3'd7, 12'h555);
    checks++;
    if (cfg_wr_err !== 1'b1) begin errors++; $display("FAIL badaddr_err: got %b want 1", cfg_wr_err); end
    cfg_addr = 3'd7;
    @(negedge mclk);
    checks++;
    if (cfg_wr_err !== 1'b0) begin errors++; $display("FAIL badaddr_err_width: got %b want 0", cfg_wr_err); end
    checks++;
    if (cfg_rdata !== 12'h000) begin errors++; $display("FAIL badaddr_rdata: got %h want 000", cfg_rdata); end
    cfg_write(3'd1, 12'h3C3); model[1] = 12'h3C3;
    checks++;
    if (cfg_wr_err !== 1'b0) begin errors++; $display("FAIL goodaddr_err: got %b want 0", cfg_wr_err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    kick();
    t = 0;
    while (rises < 31 && t < 2000) begin
      @(negedge mclk);
      t++;
    end
    checks++;
    if (rises < 31) begin errors++; $display("FAIL midreset_reach: got %0d rises want 31", rises); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, cfg_wr_err, serial_clock, serial_data, serial_load} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b want 000000",
               {busy, done, cfg_wr_err, serial_clock, serial_data, serial_load});
    end
    reset_models();
    repeat (2) @(negedge mclk);
    resetn = 1'b1;
    repeat (3) @(negedge mclk);
    checks++;
    if (load_cyc !== 0) begin errors++; $display("FAIL midreset_load: got %0d load cycles want 0", load_cyc); end
    for (int a = 0; a < NP; a++) begin
      cfg_addr = 3'(a);
      #1;
      checks++;
      if (cfg_rdata !== DEF) begin
        errors++;
        $display("FAIL midreset_rdata: addr %0d got %h want %h", a, cfg_rdata, DEF);
      end
    end
    @(negedge mclk);
    kick();
    wait_done(ok);
    checks++;
    if (!ok || busy_cyc !== 292 || rises !== 72 || load_cyc !== 2) begin
      errors++;
      $display("FAIL midreset_rerun: busy %0d rises %0d load %0d want 292 72 2", busy_cyc, rises, load_cyc);
    end
  endtask

  task automatic test_simul_div1();
    int t;
    for (int pass = 0; pass < 2; pass++) begin
      rises1 = 0; busy_cyc1 = 0; done_cnt1 = 0;
      for (int p = NP - 1; p >= 0; p--)
        for (int b = W - 1; b >= 0; b--) exp_q1.push_back(model1[p][b]);
      start1 = 1'b1;
      if (pass == 0) begin
        wr1 = 1'b1; addr1 = 3'd3; wdata1 = 12'h5A5;
        model1[3] = 12'h5A5;
      end
      @(negedge mclk);
      start1 = 1'b0; wr1 = 1'b0; addr1 = 3'd3;
      #1;
      checks++;
      if (err1 !== 1'b0) begin errors++; $display("FAIL div1_wr_err: pass %0d got %b want 0", pass, err1); end
      checks++;
      if (rdata1 !== 12'h5A5) begin errors++; $display("FAIL div1_file: pass %0d got %h want 5a5", pass, rdata1); end
      t = 0;
      while (done_cnt1 == 0 && t < 3000) begin
        @(negedge mclk);
        t++;
      end
      @(negedge mclk);
      checks++;
      if (done_cnt1 !== 1 || busy_cyc1 !== 146) begin
        errors++;
        $display("FAIL div1_busy: pass %0d busy %0d done %0d want 146 1", pass, busy_cyc1, done_cnt1);
      end
      checks++;
      if (rises1 !== 72 || exp_q1.size() != 0) begin
        errors++;
        $display("FAIL div1_bits: pass %0d rises %0d unsent %0d want 72 0", pass, rises1, exp_q1.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_xfer();
    test_pattern();
    test_busy_write();
    test_bad_addr();
    test_reset_mid();
    test_simul_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_cfg_loader.md
Name: gpio_cfg_loader

Overview:
- Upstream driver of the bottom GPIO pad-control chain.
- Holds one PAD_CTRL_BITS configuration word per pad in a local register file written by the SoC.
- On command, serialises all words onto serial_data/serial_clock, then pulses serial_load so every gpio_control_block latches its new pad configuration simultaneously.

Parameters:
- NUM_PADS, 6, number of pads in the chain.
- PAD_CTRL_BITS, 12, configuration bits per pad.
- GPIO_DEFAULT, 12'hC00, reset value of every configuration word.
- CLK_DIV, 2, half-period of serial_clock in mclk cycles (>=1).

Ports:
- mclk  input  1  block clock.
- resetn  input  1  asynchronous active-low reset.
- cfg_wr  input  1  write strobe for the configuration register file.
- cfg_addr  input  $clog2(NUM_PADS)  pad index for write and read.
- cfg_wdata  input  PAD_CTRL_BITS  write data.
- cfg_rdata  output  PAD_CTRL_BITS  combinational read of word[cfg_addr].
- cfg_wr_err  output  1  1-cycle pulse when a write is dropped.
- xfer_start  input  1  1-cycle request to load the chain.
- busy  output  1  transfer in progress.
- done  output  1  1-cycle pulse at transfer completion.
- serial_clock  output  1  chain shift clock; data is sampled on its rising edge.
- serial_data  output  1  chain serial data.
- serial_load  output  1  chain load strobe.

Behaviour:
- Clocking and reset:
  - Single clock domain, mclk.
  - resetn is asynchronous and active-low.
  - In reset: all words = GPIO_DEFAULT; FSM = IDLE; busy = done = cfg_wr_err = 0; serial_clock = serial_data = serial_load = 0.
- Register file writes:
  - Sampled on the rising edge of mclk when cfg_wr=1, busy=0 and cfg_addr<NUM_PADS.
  - A write with busy=1 or cfg_addr>=NUM_PADS is dropped, and cfg_wr_err pulses on the next cycle.
  - cfg_rdata returns 0 for out-of-range cfg_addr.
- Bit order:
  - TOTAL = NUM_PADS*PAD_CTRL_BITS bits are sent.
  - Order: word[NUM_PADS-1] MSB..LSB first, then word[NUM_PADS-2], and so on, ending with word[0] LSB.
  - The first bit shifted ends up in the farthest pad; word[0] lands in pad 0.
- Snapshot:
  - On accept, the file is copied into a TOTAL-bit shift register.
  - Shifting uses only the snapshot.
- FSM states:
  - IDLE: if xfer_start=1, capture the snapshot, clear the bit counter, and go to SHIFT_LO. busy goes 1 from the next cycle. xfer_start while busy is ignored.
  - SHIFT_LO (CLK_DIV cycles): serial_clock=0, serial_data=current bit, stable for the whole state.
  - SHIFT_HI (CLK_DIV cycles): serial_clock=1, serial_data held.
    - On exit, if bit counter = TOTAL-1, go to LOAD_LO.
    - Otherwise shift the snapshot, increment the counter, and go to SHIFT_LO.
  - LOAD_LO (CLK_DIV cycles): serial_clock=0, serial_data=0, serial_load=0.
  - LOAD_HI (CLK_DIV cycles): serial_load=1, serial_clock=0.
  - DONE (1 cycle): busy=0, done=1, serial outputs 0, then go to IDLE.
- Timing:
  - busy is high for exactly 2*CLK_DIV*(TOTAL+1) cycles.
  - The done pulse immediately follows the last busy cycle.
  - Exactly TOTAL rising edges on serial_clock per transfer.
  - serial_load is never high while serial_clock is high.
- Counters:
  - Phase counter width is $clog2(CLK_DIV+1); it resets to 0 on every state entry.
  - Bit counter width is $clog2(TOTAL+1).
  - No wrap-around within a transfer.
- Simultaneous events:
  - cfg_wr and xfer_start in the same IDLE cycle: the write is applied and the snapshot uses the pre-write value (snapshot is taken from register state before the edge).
  - The write succeeds and does not raise cfg_wr_err.
- Reset mid-transfer: immediate return to reset state, no load pulse, and register-file contents revert to GPIO_DEFAULT.

Test Plan:
- Reset then xfer_start with defaults (NUM_PADS=6, CLK_DIV=2):
  - 72 serial_clock rising edges.
  - Bit pattern 1100_0000_0000 repeated 6 times.
  - serial_load high 2 cycles.
  - busy high 292 cycles, then done=1 for 1 cycle.
- Write word[5]=12'hABC, word[0]=12'h123, others default, then start:
  - First 12 bits sampled = A,B,C MSB-first.
  - Last 12 bits sampled = 1,2,3.
  - A 6-stage behavioural chain model latches 12'hABC in pad 5 and 12'h123 in pad 0.
- During busy, cfg_wr to addr 2 with 12'hFFF and a second xfer_start:
  - cfg_wr_err pulses once.
  - word[2] is unchanged.
  - Exactly one done.
- cfg_wr addr 7:
  - cfg_wr_err=1 one cycle.
  - cfg_rdata at addr 7 = 0.
- Deassert resetn after bit 30 of a transfer:
  - All outputs 0 asynchronously.
  - No serial_load pulse.
  - cfg_rdata at any addr = 12'hC00.
  - A new start completes normally.
- CLK_DIV=1 with cfg_wr and xfer_start in the same cycle:
  - Snapshot holds the old value; the file holds the new value.
  - busy high 146 cycles.
